// File: rtl/lift_ctrl_fsm.sv
// Purpose : directional-collective sequencing controller for a single 6-floor lift car.
// Latency : every output is registered; a decision on the sampled Sensor/call inputs appears one edge later.
// Backpr. : none; Sensor and the call vectors are level inputs, and OpenDoor acts as the clear strobe back to the call register.
//
// Ports
//   clk, rst        clock (rising edge) and synchronous active-high reset
//   Sensor[5:0]     one-hot floor alignment; 0 means the car is between floors
//   Hall_call_Up    latched up-calls, bit i = floor i (floors 0..4)
//   Hall_call_Down  latched down-calls, bit i = floor i (floors 1..5)
//   Car_call        latched in-car calls, bit i = floor i (floors 0..5)
//   Motor_up/down   motor drive; OpenDoor is the door drive and the call-clear strobe
//   Dir_up          current travel preference; Floor is the last valid floor; Fault is sticky
module lift_ctrl_fsm #(
  parameter int DOOR_CYCLES = 8,
  parameter int TIMER_W     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Sensor,
  input  logic [4:0] Hall_call_Up,
  input  logic [5:1] Hall_call_Down,
  input  logic [5:0] Car_call,
  output logic       Motor_up,
  output logic       Motor_down,
  output logic       OpenDoor,
  output logic       Dir_up,
  output logic [2:0] Floor,
  output logic       Fault
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_UP     = 2'd1;
  localparam logic [1:0] ST_DOWN   = 2'd2;
  localparam logic [1:0] ST_DOOR   = 2'd3;

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(DOOR_CYCLES - 1);

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic               dir_nxt;
  logic               left;
  logic [TIMER_W-1:0] timer;

  // Floors strictly above f.
  function automatic logic [5:0] mask_above(input logic [2:0] f);
    mask_above = 6'b111111 << (f + 3'd1);
  endfunction

  // Floors strictly below f.
  function automatic logic [5:0] mask_below(input logic [2:0] f);
    logic [5:0] one_hot;
    one_hot    = 6'b000001 << f;
    mask_below = one_hot - 6'd1;
  endfunction

  // ------------------------------------------------------------------
  // Sensor decode. A multi-hot pattern is a sensor fault; it is treated
  // exactly like "between floors" so it can never trigger a stop.
  // ------------------------------------------------------------------
  logic       sensor_multi;
  logic       sensor_ok;
  logic [2:0] sensor_idx;

  always_comb begin
    sensor_idx = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (Sensor[i]) begin
        sensor_idx = 3'(i);
      end
    end
    sensor_multi = (Sensor & (Sensor - 6'd1)) != 6'd0;
    sensor_ok    = (Sensor != 6'd0) && !sensor_multi;
  end

  // ------------------------------------------------------------------
  // Request sets. Hall calls are re-based onto a 6-bit floor vector so
  // every set can be masked by floor index uniformly.
  // ------------------------------------------------------------------
  logic [5:0] up_ext;
  logic [5:0] dn_ext;
  logic [5:0] req;
  logic       here;
  logic       above;
  logic       below;

  assign up_ext = {1'b0, Hall_call_Up};
  assign dn_ext = {Hall_call_Down, 1'b0};
  assign req    = Car_call | up_ext | dn_ext;

  assign here  = |(req & (6'b000001 << Floor));
  assign above = |(req & mask_above(Floor));
  assign below = |(req & mask_below(Floor));

  // Direction choice shared by IDLE and door close; a tie keeps Dir_up.
  logic go_up;
  logic go_down;

  assign go_up   = above && (Dir_up || !below);
  assign go_down = !go_up && below;

  // ------------------------------------------------------------------
  // Stop decision at the floor being sensed right now. Only valid once
  // the car has left its departure floor (left=1).
  // ------------------------------------------------------------------
  logic [5:0] sel;
  logic       req_at;
  logic       stop_up;
  logic       stop_down;

  assign sel    = 6'b000001 << sensor_idx;
  assign req_at = |(req & sel);

  // The terminal floor always stops the car: there is nowhere further to go.
  assign stop_up = sensor_ok && left &&
                   ((|((Car_call | up_ext) & sel)) ||
                    (req_at && !(|(req & mask_above(sensor_idx)))) ||
                    (sensor_idx == 3'd5));

  assign stop_down = sensor_ok && left &&
                     ((|((Car_call | dn_ext) & sel)) ||
                      (req_at && !(|(req & mask_below(sensor_idx)))) ||
                      (sensor_idx == 3'd0));

  // ------------------------------------------------------------------
  // Next-state logic.
  // ------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    dir_nxt   = Dir_up;
    case (state)
      ST_IDLE: begin
        if (here) begin
          state_nxt = ST_DOOR;
        end else if (go_up) begin
          state_nxt = ST_UP;
          dir_nxt   = 1'b1;
        end else if (go_down) begin
          state_nxt = ST_DOWN;
          dir_nxt   = 1'b0;
        end
      end

      // A non-terminal stop always has req_at set, so req_at alone decides
      // between opening the door and parking at an empty terminal floor.
      ST_UP: begin
        if (stop_up) begin
          state_nxt = req_at ? ST_DOOR : ST_IDLE;
        end
      end

      ST_DOWN: begin
        if (stop_down) begin
          state_nxt = req_at ? ST_DOOR : ST_IDLE;
        end
      end

      // Calls at this floor are being cleared by OpenDoor, so 'here' is
      // deliberately ignored at close; it must not hold the door open.
      ST_DOOR: begin
        if (timer == TIMER_LAST) begin
          if (go_up) begin
            state_nxt = ST_UP;
            dir_nxt   = 1'b1;
          end else if (go_down) begin
            state_nxt = ST_DOWN;
            dir_nxt   = 1'b0;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // State and registered outputs. Outputs decode state_nxt so the motor
  // drops and the door rises on the same edge.
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      Motor_up   <= 1'b0;
      Motor_down <= 1'b0;
      OpenDoor   <= 1'b0;
      Dir_up     <= 1'b1;
      Floor      <= 3'd0;
      Fault      <= 1'b0;
      timer      <= '0;
      left       <= 1'b0;
    end else begin
      state      <= state_nxt;
      Dir_up     <= dir_nxt;
      Motor_up   <= (state_nxt == ST_UP);
      Motor_down <= (state_nxt == ST_DOWN);
      OpenDoor   <= (state_nxt == ST_DOOR);

      if (sensor_ok) begin
        Floor <= sensor_idx;
      end
      if (sensor_multi) begin
        Fault <= 1'b1;
      end

      // Timer runs only while the door stays open; it is zero on entry.
      if (state == ST_DOOR && state_nxt == ST_DOOR) begin
        timer <= timer + 1'b1;
      end else begin
        timer <= '0;
      end

      // 'left' masks the departure floor: cleared on entering a move,
      // set the first time the car is seen between floors.
      if ((state_nxt == ST_UP || state_nxt == ST_DOWN) && state_nxt != state) begin
        left <= 1'b0;
      end else if ((state == ST_UP || state == ST_DOWN) && !sensor_ok) begin
        left <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lift_ctrl_fsm.sv
// Purpose : scoreboard bench for lift_ctrl_fsm driving directed floor-sensor journeys.
// Latency : expectations are queued ahead of stimulus; the monitor compares on every output change.
// Backpr. : none; the bench emulates the call register, clearing calls at Floor while OpenDoor is high.
module tb_lift_ctrl_fsm;

  logic       clk;
  logic       rst;
  logic [5:0] sensor;
  logic [4:0] hall_up;
  logic [5:1] hall_dn;
  logic [5:0] car_call;
  logic       motor_up;
  logic       motor_down;
  logic       open_door;
  logic       dir_up;
  logic [2:0] floor_idx;
  logic       fault;

  lift_ctrl_fsm #(.DOOR_CYCLES(8), .TIMER_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .Sensor         (sensor),
    .Hall_call_Up   (hall_up),
    .Hall_call_Down (hall_dn),
    .Car_call       (car_call),
    .Motor_up       (motor_up),
    .Motor_down     (motor_down),
    .OpenDoor       (open_door),
    .Dir_up         (dir_up),
    .Floor          (floor_idx),
    .Fault          (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output-tuple changes {up, down, door, dir, floor[2:0], fault}
  // and expected door-open durations, in order of occurrence.
  logic [7:0] exp_q[$];
  int         door_q[$];
  logic       done;
  int         total;
  int         bad;

  function automatic logic [7:0] tp(input logic u, input logic d, input logic o,
                                    input logic dr, input logic [2:0] fl, input logic f);
    tp = {u, d, o, dr, fl, f};
  endfunction

  task automatic ex(input logic [7:0] v);
    exp_q.push_back(v);
  endtask

  task automatic exd(input int n);
    door_q.push_back(n);
  endtask

  // Advance n edges; model the call register clear while the door is open.
  task automatic tick(input int n);
    logic [5:0] m;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (open_door) begin
        m        = 6'b000001 << floor_idx;
        car_call = car_call & ~m;
        hall_up  = hall_up & ~m[4:0];
        hall_dn  = hall_dn & ~m[5:1];
      end
    end
  endtask

  // Car travels off its floor and aligns with floor f.
  task automatic step(input int f);
    sensor = 6'd0;
    tick(2);
    sensor = 6'b000001 << f;
    tick(3);
  endtask

  // Monitor: compares on every change of the output tuple and on every door close.
  initial begin
    logic [7:0] cur;
    logic [7:0] prev;
    logic [7:0] e;
    logic       first;
    int         door_cnt;
    int         evt;
    int         dexp;
    total    = 0;
    bad      = 0;
    first    = 1'b1;
    door_cnt = 0;
    evt      = 0;
    prev     = 8'd0;
    forever begin
      @(negedge clk);
      if (done) begin
        while (exp_q.size() != 0) begin
          e     = exp_q.pop_front();
          total = total + 1;
          bad   = bad + 1;
          $display("FAIL out_evt%0d never seen: required=%b", evt, e);
          evt   = evt + 1;
        end
        while (door_q.size() != 0) begin
          dexp  = door_q.pop_front();
          total = total + 1;
          bad   = bad + 1;
          $display("FAIL door_len never seen: required=%0d", dexp);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
      cur = {motor_up, motor_down, open_door, dir_up, floor_idx, fault};
      if (first || cur != prev) begin
        total = total + 1;
        if (exp_q.size() == 0) begin
          bad = bad + 1;
          $display("FAIL out_evt%0d unexpected change: got=%b required=none", evt, cur);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            bad = bad + 1;
            $display("FAIL out_evt%0d u/d/o/dir/floor/fault got=%b required=%b", evt, cur, e);
          end
        end
        evt = evt + 1;
      end
      first = 1'b0;
      prev  = cur;
      if (open_door) begin
        door_cnt = door_cnt + 1;
      end else if (door_cnt != 0) begin
        total = total + 1;
        if (door_q.size() == 0) begin
          bad = bad + 1;
          $display("FAIL door_len unexpected door: got=%0d required=none", door_cnt);
        end else begin
          dexp = door_q.pop_front();
          if (door_cnt != dexp) begin
            bad = bad + 1;
            $display("FAIL door_len got=%0d required=%0d", door_cnt, dexp);
          end
        end
        door_cnt = 0;
      end
    end
  end

  // Stimulus: directed journeys with hand-derived output sequences.
  initial begin
    done     = 1'b0;
    rst      = 1'b1;
    sensor   = 6'b000001;
    hall_up  = 5'd0;
    hall_dn  = 5'd0;
    car_call = 6'd0;
    ex(tp(0, 0, 0, 1, 3'd0, 0));               // reset state
    tick(3);

    // T1: floor 0, car call 3 -> up, stop at 3, door 8, idle.
    ex(tp(1, 0, 0, 1, 3'd0, 0));
    rst      = 1'b0;
    car_call = 6'b001000;
    tick(2);
    ex(tp(1, 0, 0, 1, 3'd1, 0)); step(1);
    ex(tp(1, 0, 0, 1, 3'd2, 0)); step(2);
    ex(tp(0, 0, 1, 1, 3'd3, 0)); ex(tp(0, 0, 0, 1, 3'd3, 0)); exd(8);
    step(3);
    tick(10);

    // T3: idle at 3, up-call at 3 -> door on next edge, no motor.
    ex(tp(0, 0, 1, 1, 3'd3, 0)); ex(tp(0, 0, 0, 1, 3'd3, 0)); exd(8);
    hall_up = 5'b01000;
    tick(12);

    // T2 setup: down to floor 2, then while the door is open the calls
    // down@4 and car@5 arrive; car passes 4 going up, stops at 5, returns to 4.
    ex(tp(0, 1, 0, 0, 3'd3, 0));
    car_call = 6'b000100;
    tick(2);
    ex(tp(0, 0, 1, 0, 3'd2, 0)); ex(tp(1, 0, 0, 1, 3'd2, 0)); exd(8);
    step(2);
    hall_dn[4]  = 1'b1;
    car_call[5] = 1'b1;
    tick(8);
    ex(tp(1, 0, 0, 1, 3'd3, 0)); step(3);
    ex(tp(1, 0, 0, 1, 3'd4, 0)); step(4);
    ex(tp(0, 0, 1, 1, 3'd5, 0)); ex(tp(0, 1, 0, 0, 3'd5, 0)); exd(8);
    step(5);
    tick(10);
    ex(tp(0, 0, 1, 0, 3'd4, 0)); ex(tp(0, 0, 0, 0, 3'd4, 0)); exd(8);
    step(4);
    tick(10);

    // T4 setup: down to 1, then up to 2 so the car idles at 2 with Dir_up=1.
    ex(tp(0, 1, 0, 0, 3'd4, 0));
    car_call = 6'b000010;
    tick(2);
    ex(tp(0, 1, 0, 0, 3'd3, 0)); step(3);
    ex(tp(0, 1, 0, 0, 3'd2, 0)); step(2);
    ex(tp(0, 0, 1, 0, 3'd1, 0)); ex(tp(0, 0, 0, 0, 3'd1, 0)); exd(8);
    step(1);
    tick(10);
    ex(tp(1, 0, 0, 1, 3'd1, 0));
    car_call[2] = 1'b1;
    tick(2);
    ex(tp(0, 0, 1, 1, 3'd2, 0)); ex(tp(0, 0, 0, 1, 3'd2, 0)); exd(8);
    step(2);
    tick(10);

    // T4: calls at 0 and 5 together with Dir_up=1 -> up first.
    ex(tp(1, 0, 0, 1, 3'd2, 0));
    car_call[0] = 1'b1;
    car_call[5] = 1'b1;
    tick(2);
    ex(tp(1, 0, 0, 1, 3'd3, 0)); step(3);
    ex(tp(1, 0, 0, 1, 3'd4, 0)); step(4);
    ex(tp(0, 0, 1, 1, 3'd5, 0)); ex(tp(0, 1, 0, 0, 3'd5, 0)); exd(8);
    step(5);
    car_call[3] = 1'b1;
    tick(10);

    // T5: multi-hot sensor while leaving 5 -> Fault, Floor holds, no stop.
    ex(tp(0, 1, 0, 0, 3'd5, 1));
    sensor = 6'b000110;
    tick(2);
    ex(tp(0, 1, 0, 0, 3'd4, 1)); step(4);

    // T6: stop at 3, rst during the third door cycle -> reset tuple.
    ex(tp(0, 0, 1, 0, 3'd3, 1)); exd(3);
    sensor = 6'd0;
    tick(2);
    sensor = 6'b001000;
    tick(1);
    tick(2);
    ex(tp(0, 0, 0, 1, 3'd0, 0));
    rst      = 1'b1;
    car_call = 6'd0;
    hall_up  = 5'd0;
    hall_dn  = 5'd0;
    tick(2);
    // After release the car is still aligned at 3, so Floor relearns 3.
    ex(tp(0, 0, 0, 1, 3'd3, 0));
    rst = 1'b0;
    tick(6);
    done = 1'b1;
  end

endmodule
